// File: rtl/instruction_loader_pkg.sv
// Shared types and frame constants for the instruction loader,
// its byte-lane assembler and any host-link model that drives it.
package instruction_loader_pkg;

  typedef logic [31:0] word;

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } load_state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// Collects four stream bytes into a little-endian word and
// pulses word_valid the cycle after the fourth byte lands.
module instruction_loader_word_assembler
  import instruction_loader_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] data,
  output logic       last,
  output word        word_out,
  output logic       word_valid
);

  logic [1:0]  byte_idx;
  logic [23:0] lanes;

  assign last = (byte_idx == LAST_LANE);

  always_ff @(posedge clock) begin
    if (reset) begin
      byte_idx   <= 2'd0;
      lanes      <= 24'd0;
      word_out   <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= en && last;
      if (en) begin
        byte_idx <= byte_idx + 2'd1;
        unique case (byte_idx)
          2'd0: lanes[7:0]   <= data;
          2'd1: lanes[15:8]  <= data;
          2'd2: lanes[23:16] <= data;
          2'd3: word_out     <= {data, lanes};
        endcase
      end
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Loads a framed byte stream into instruction memory and holds
// the core in reset until a checksummed frame has landed.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output word                   imem_wdata,
  output logic                  core_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int         MAX_WORDS = 2 ** ADDR_WIDTH;
  localparam logic [16:0] MAX_N    = 17'(MAX_WORDS);

  load_state_t state;
  logic [7:0]  len_lo;
  logic [15:0] n;
  logic [7:0]  checksum;
  logic        accept;
  logic        asm_en;
  logic        last;
  logic [15:0] n_in;
  logic [16:0] cnt_next;

  assign in_ready = (state == S_LEN0) || (state == S_LEN1)
                 || (state == S_DATA) || (state == S_CHECK);
  assign busy     = (state == S_LEN1) || (state == S_DATA)
                 || (state == S_CHECK);
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERROR);

  assign accept   = in_valid && in_ready;
  assign asm_en   = accept && (state == S_DATA);
  assign n_in     = {in_data, len_lo};
  assign cnt_next = 17'(words_loaded) + 17'd1;

  instruction_loader_word_assembler u_asm (
    .clock      (clock),
    .reset      (reset),
    .en         (asm_en),
    .data       (in_data),
    .last       (last),
    .word_out   (imem_wdata),
    .word_valid (imem_we)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_LEN0;
      len_lo       <= 8'd0;
      n            <= 16'd0;
      checksum     <= 8'd0;
      words_loaded <= '0;
      imem_addr    <= '0;
      core_reset   <= 1'b1;
    end else begin
      core_reset <= (state != S_DONE);
      if (accept) begin
        unique case (state)
          S_LEN0: begin
            len_lo <= in_data;
            state  <= S_LEN1;
          end
          S_LEN1: begin
            n <= n_in;
            if ({1'b0, n_in} > MAX_N)
              state <= S_ERROR;
            else if (n_in == 16'd0)
              state <= S_CHECK;
            else
              state <= S_DATA;
          end
          S_DATA: begin
            checksum <= checksum ^ in_data;
            // address and count are set together so they line up with imem_we
            if (last) begin
              imem_addr    <= words_loaded[ADDR_WIDTH-1:0];
              words_loaded <= words_loaded
                            + {{ADDR_WIDTH{1'b0}}, 1'b1};
              if (cnt_next == {1'b0, n})
                state <= S_CHECK;
            end
          end
          S_CHECK: begin
            state <= (in_data == checksum) ? S_DONE : S_ERROR;
          end
          S_DONE, S_ERROR: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed and randomized frames checked against a frame-level
// model of what the loader must write and report.
module tb_instruction_loader;
  import instruction_loader_pkg::*;

  localparam int AW  = 10;
  localparam int MAX = 2 ** AW;

  typedef logic [7:0] bq_t[$];
  typedef word        wq_t[$];

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  word           imem_wdata;
  logic          core_reset;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] wr_addr[$];
  word           wr_data[$];
  logic [AW:0]   wr_cnt[$];
  int            done_age = 0;
  logic          cr_at_rise = 1'b0;
  logic          cr_after   = 1'b1;

  instruction_loader #(.ADDR_WIDTH(AW)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_reset   (core_reset),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset && imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      wr_cnt.push_back(words_loaded);
    end
    if (!done) done_age = 0;
    else begin
      done_age++;
      if (done_age == 1) cr_at_rise = core_reset;
      if (done_age == 2) cr_after = core_reset;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Frame builder: header, little-endian payload, XOR of payload.
  task automatic make_frame(input int n_hdr, input wq_t ws,
                            input bit bad_chk, output bq_t f);
    logic [7:0] x;
    logic [7:0] b;
    f = {};
    f.push_back(8'(n_hdr % 256));
    f.push_back(8'(n_hdr / 256));
    x = 8'h00;
    foreach (ws[i])
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        b = 8'((ws[i] / (32'd1 << (8 * k))) % 256);
        f.push_back(b);
        x = x ^ b;
      end
    f.push_back(bad_chk ? (x ^ 8'h01) : x);
  endtask

  task automatic send(input bq_t f, input int pct);
    int guard;
    foreach (f[i]) begin
      guard = 0;
      while (pct > 0 && $urandom_range(99) < pct && guard < 8) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        guard++;
        @(negedge clock);
      end
      in_valid = 1'b1;
      in_data  = f[i];
      @(negedge clock);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic check_frame(input string tag, input int base,
                             input wq_t ew, input bit ok);
    int n;
    n = wr_addr.size() - base;
    chk({tag, "_nwr"}, 64'(n), 64'(ew.size()));
    for (int i = 0; i < n && i < ew.size(); i++) begin
      chk({tag, "_addr"}, 64'(wr_addr[base+i]), 64'(i));
      chk({tag, "_data"}, 64'(wr_data[base+i]), 64'(ew[i]));
      chk({tag, "_cnt"},  64'(wr_cnt[base+i]),  64'(i + 1));
    end
    chk({tag, "_done"},  64'(done),       64'(ok));
    chk({tag, "_error"}, 64'(error),      64'(!ok));
    chk({tag, "_crst"},  64'(core_reset), 64'(!ok));
    chk({tag, "_rdy"},   64'(in_ready),   64'd0);
    chk({tag, "_busy"},  64'(busy),       64'd0);
    chk({tag, "_wl"},    64'(words_loaded), 64'(ew.size()));
  endtask

  task automatic rand_words(input int n, output wq_t ws);
    ws = {};
    for (int i = 0; i < n; i++) ws.push_back(word'($urandom));
  endtask

  initial begin
    bq_t f;
    wq_t ws;
    wq_t none;
    int  base;

    none = {};
    do_reset();
    chk("rst_ready", 64'(in_ready),     64'd1);
    chk("rst_we",    64'(imem_we),      64'd0);
    chk("rst_addr",  64'(imem_addr),    64'd0);
    chk("rst_wdata", 64'(imem_wdata),   64'd0);
    chk("rst_crst",  64'(core_reset),   64'd1);
    chk("rst_busy",  64'(busy),         64'd0);
    chk("rst_done",  64'(done),         64'd0);
    chk("rst_error", 64'(error),        64'd0);
    chk("rst_wl",    64'(words_loaded), 64'd0);

    ws = {32'h0000_0013, 32'h0010_0093};
    make_frame(2, ws, 1'b0, f);
    base = wr_addr.size();
    send(f, 0);
    check_frame("good2", base, ws, 1'b1);
    chk("good2_w1_const", 64'(wr_data[base+1]), 64'h0010_0093);
    chk("good2_crst_rise", 64'(cr_at_rise), 64'd1);
    chk("good2_crst_after", 64'(cr_after), 64'd0);

    do_reset();
    chk("busy_idle", 64'(busy), 64'd0);
    make_frame(2, ws, 1'b1, f);
    base = wr_addr.size();
    send(f, 0);
    check_frame("badchk", base, ws, 1'b0);

    do_reset();
    make_frame(0, none, 1'b0, f);
    base = wr_addr.size();
    send(f, 0);
    check_frame("empty", base, none, 1'b1);

    do_reset();
    base = wr_addr.size();
    f = {8'h01, 8'h04};
    send(f, 0);
    chk("ovf_error_now", 64'(error), 64'd1);
    f = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send(f, 0);
    check_frame("ovf", base, none, 1'b0);

    do_reset();
    rand_words(2, ws);
    make_frame(2, ws, 1'b0, f);
    base = wr_addr.size();
    send(f, 0);
    check_frame("rnd_nogap", base, ws, 1'b1);
    do_reset();
    base = wr_addr.size();
    send(f, 50);
    check_frame("rnd_gap", base, ws, 1'b1);

    for (int t = 0; t < 4; t++) begin
      do_reset();
      rand_words(1 + $urandom_range(24), ws);
      make_frame(ws.size(), ws, 1'(t % 2), f);
      base = wr_addr.size();
      send(f, 30);
      check_frame(t % 2 ? "rnd_bad" : "rnd_ok", base, ws, !(t % 2));
    end

    do_reset();
    base = wr_addr.size();
    chk("mid_busy_pre", 64'(busy), 64'd0);
    f = {8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA5, 8'h5A};
    send(f, 0);
    chk("mid_busy", 64'(busy), 64'd1);
    chk("mid_partial_wr", 64'(wr_addr.size() - base), 64'd1);
    do_reset();
    f = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    base = wr_addr.size();
    send(f, 0);
    ws = {32'hDEAD_BEEF};
    check_frame("mid_reset", base, ws, 1'b1);

    do_reset();
    rand_words(MAX, ws);
    make_frame(MAX, ws, 1'b0, f);
    base = wr_addr.size();
    send(f, 0);
    check_frame("max", base, ws, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
